uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx_drain.sv | 96 +++++++++
 tb/tb_uart_tx_drain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame timing constants for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-cycle counter, pulses bit_end on the last cycle of each serial bit
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLK_50,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_end = enable && (count == LAST);

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains a show-ahead FIFO onto an 8N1 UART line, one pop per frame
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic [7:0] FIFO_RD_DATA,
  input  logic       FIFO_EMPTY,
  output logic       FIFO_RD_EN,
  output logic       TX,
  output logic       TX_BUSY,
  output logic       TX_DONE
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t  state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       start_frame;
  logic       counting;

  // EMPTY only matters while idle; the byte is latched and popped on this one edge
  assign start_frame = (state == IDLE) && !FIFO_EMPTY;
  assign counting    = (state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK_50 (CLK_50),
    .RESET_N(RESET_N),
    .clear  (start_frame),
    .enable (counting),
    .bit_end(bit_end)
  );

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      FIFO_RD_EN <= 1'b0;
      TX         <= 1'b1;
      TX_BUSY    <= 1'b0;
      TX_DONE    <= 1'b0;
    end else begin
      FIFO_RD_EN <= 1'b0;
      TX_DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_frame) begin
            state      <= START;
            shift_reg  <= FIFO_RD_DATA;
            bit_idx    <= '0;
            FIFO_RD_EN <= 1'b1;
            TX         <= 1'b0;
            TX_BUSY    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            TX    <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              // next bit is the one that lands in bit 0 after this shift
              TX <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            TX_BUSY <= 1'b0;
            TX_DONE <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - randomized self-checking bench for uart_tx_drain against a waveform model
`timescale 1ns/1ps
module tb_uart_tx_drain;

  localparam int CPB   = 434;
  localparam int CPB_S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rd_data_d, rd_data_s;
  logic       empty_d, empty_s;
  logic       rd_en_d, tx_d, busy_d, done_d;
  logic       rd_en_s, tx_s, busy_s, done_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops_d   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_drain dut (
    .CLK_50(clk), .RESET_N(rst_n), .FIFO_RD_DATA(rd_data_d), .FIFO_EMPTY(empty_d),
    .FIFO_RD_EN(rd_en_d), .TX(tx_d), .TX_BUSY(busy_d), .TX_DONE(done_d)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB_S)) dut_s (
    .CLK_50(clk), .RESET_N(rst_n), .FIFO_RD_DATA(rd_data_s), .FIFO_EMPTY(empty_s),
    .FIFO_RD_EN(rd_en_s), .TX(tx_s), .TX_BUSY(busy_s), .TX_DONE(done_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Line level k cycles after the first START cycle: start bit, data LSB first, stop/idle high
  function automatic logic exp_tx(input logic [7:0] b, input int k, input int cpb);
    int idx;
    if (k < cpb) return 1'b0;
    if (k < 9 * cpb) begin
      idx = (k - cpb) / cpb;
      return b[idx[2:0]];
    end
    return 1'b1;
  endfunction

  // Show-ahead FIFO model; inputs change 1ns after the falling edge
  initial begin
    empty_d   = 1'b1;
    rd_data_d = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rd_en_d === 1'b1) begin
        pops_d++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      empty_d   = (fifo_q.size() == 0);
      rd_data_d = empty_d ? 8'h00 : fifo_q[0];
    end
  end

  task automatic push(input logic [7:0] b);
    push_q.push_back(b);
  endtask

  task automatic wait_start(input string tag, output int start_cyc);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (rd_en_d !== 1'b1 && waited < 20 * CPB);
    chk({tag, "_start"}, {31'd0, rd_en_d}, 32'd1);
    start_cyc = cyc;
  endtask

  task automatic expect_frame(input logic [7:0] b, input int inject_k, input logic [7:0] inject_b,
                              input string tag, output int start_cyc);
    int errs;
    int bi;
    logic [7:0] dec;
    errs = 0;
    dec  = 8'h00;
    wait_start(tag, start_cyc);
    for (int k = 0; k <= 10 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k == inject_k) push(inject_b);
      if (tx_d !== exp_tx(b, k, CPB)) errs++;
      if (busy_d !== (k < 10 * CPB)) errs++;
      if (done_d !== (k == 10 * CPB)) errs++;
      if (rd_en_d !== (k == 0)) errs++;
      if (k >= CPB && k < 9 * CPB && (k - CPB) % CPB == CPB / 2) begin
        bi = (k - CPB) / CPB;
        dec[bi[2:0]] = tx_d;
      end
    end
    chk({tag, "_wave"}, errs, 0);
    chk({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
  endtask

  initial begin
    int s0, s1, s2, errs, waited, inj, n;
    logic [7:0] b, nb;
    logic [7:0] exp_q[$];

    rd_data_s = 8'h00;
    empty_s   = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, tx_d},    32'd1);
    chk("rst_busy",  {31'd0, busy_d},  32'd0);
    chk("rst_rd_en", {31'd0, rd_en_d}, 32'd0);
    chk("rst_done",  {31'd0, done_d},  32'd0);
    rst_n = 1'b1;

    // Short-bit instance: 0x80 then random bytes, 40-cycle frames
    for (int i = 0; i < 9; i++) begin
      b = (i == 0) ? 8'h80 : 8'($urandom);
      rd_data_s = b;
      empty_s   = 1'b0;
      waited    = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (rd_en_s !== 1'b1 && waited < 50);
      empty_s   = 1'b1;
      rd_data_s = 8'h00;
      errs = (rd_en_s === 1'b1) ? 0 : 1;
      for (int k = 0; k <= 10 * CPB_S; k++) begin
        if (k > 0) @(negedge clk);
        if (tx_s !== exp_tx(b, k, CPB_S)) errs++;
        if (busy_s !== (k < 10 * CPB_S)) errs++;
        if (done_s !== (k == 10 * CPB_S)) errs++;
        if (rd_en_s !== (k == 0)) errs++;
      end
      chk($sformatf("sweep_%02h", b), errs, 0);
    end

    // Asynchronous reset while the start bit is on the line
    rd_data_s = 8'h00;
    empty_s   = 1'b0;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (rd_en_s !== 1'b1 && waited < 50);
    empty_s = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_tx",   {31'd0, tx_s},   32'd1);
    chk("async_busy", {31'd0, busy_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    errs = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (tx_d !== 1'b1 || busy_d !== 1'b0 || rd_en_d !== 1'b0 || done_d !== 1'b0) errs++;
    end
    chk("empty_idle", errs, 0);

    push(8'h41);
    expect_frame(8'h41, -1, 8'h00, "single", s0);
    chk("single_pops", pops_d, 1);

    push(8'h55);
    push(8'hAA);
    push(8'h0D);
    expect_frame(8'h55, -1, 8'h00, "b2b0", s0);
    expect_frame(8'hAA, -1, 8'h00, "b2b1", s1);
    expect_frame(8'h0D, -1, 8'h00, "b2b2", s2);
    chk("b2b_gap01", s1 - s0, 10 * CPB + 1);
    chk("b2b_gap12", s2 - s1, 10 * CPB + 1);
    chk("b2b_pops", pops_d, 4);

    // Second byte arrives somewhere inside the stop bit
    push(8'hC3);
    expect_frame(8'hC3, 9 * CPB + int'($urandom_range(0, CPB - 1)), 8'h3C, "late1", s0);
    expect_frame(8'h3C, -1, 8'h00, "late2", s1);
    chk("late_gap", s1 - s0, 10 * CPB + 1);

    push(8'hFF);
    wait_start("rstff", s0);
    n = 4 * CPB + int'($urandom_range(0, CPB - 1));
    repeat (n) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tx",   {31'd0, tx_d},   32'd1);
    chk("midrst_busy", {31'd0, busy_d}, 32'd0);
    push(8'h33);
    repeat (3) @(negedge clk);
    chk("midrst_rd_en", {31'd0, rd_en_d}, 32'd0);
    rst_n = 1'b1;
    expect_frame(8'h33, -1, 8'h00, "after_rst", s0);

    b  = 8'($urandom);
    nb = 8'($urandom);
    push(b);
    push(nb);
    exp_q.push_back(b);
    exp_q.push_back(nb);
    inj = 0;
    s1  = -1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      b = exp_q.pop_front();
      if (inj < 2) begin
        nb = 8'($urandom);
        exp_q.push_back(nb);
        inj++;
        expect_frame(b, int'($urandom_range(1, 10 * CPB - 1)), nb, $sformatf("rnd%0d", i), s0);
      end else begin
        expect_frame(b, -1, 8'h00, $sformatf("rnd%0d", i), s0);
      end
      if (s1 >= 0) chk($sformatf("rnd%0d_gap", i), s0 - s1, 10 * CPB + 1);
      s1 = s0;
    end

    repeat (5) @(negedge clk);
    chk("total_pops", pops_d, 12);
    chk("fifo_drained", fifo_q.size(), 0);
    chk("final_idle_busy", {31'd0, busy_d}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
